rv32_lsu_ctrl: RTL and testbench
================================

// Module: rv32_lsu_ctrl
// PURPOSE
//  Load/store access controller between the multicycle RV32I control FSM and the data memory.
//  Replaces the raw mem_rd_en/wr_en/data_length strobes with a request/response handshake.
//  Adds per-byte lane enables, write-data lane replication, load sign/zero extension,
//  misalignment detection and tolerance of memory wait states.
// PARAMETERS
//  ADDR_W       32  width of req_addr and mem_address
//  TIMEOUT_CYC  16  max ACCESS cycles before abort (used only with LSU_TIMEOUT_EN); range 2..255
// PORTS
//  clk              in   1       single clock, all state updates on rising edge
//  reset_n          in   1       synchronous, active-low reset
//  req_valid        in   1       FSM requests a memory access
//  req_ready        out  1       controller can accept a request (IDLE only)
//  req_we           in   1       1 = store, 0 = load
//  req_size         in   2       00 byte, 01 half, 10 word, 11 illegal
//  req_unsigned     in   1       1 = zero-extend load (LBU/LHU), 0 = sign-extend
//  req_addr         in   ADDR_W  byte address
//  req_wdata        in   32      store data, right-aligned
//  rsp_valid        out  1       one-cycle pulse: access complete
//  rsp_rdata        out  32      extended load data (0 for stores and errors)
//  rsp_err          out  1       valid with rsp_valid: misaligned/illegal (or timeout)
//  mem_rd_en        out  1       memory read strobe
//  mem_wr_en        out  1       memory write strobe
//  mem_address      out  ADDR_W  word-aligned address {req_addr[ADDR_W-1:2],2'b00}
//  mem_wdata        out  32      lane-replicated store data
//  mem_byte_en      out  4       byte lane enables
//  mem_data_length  out  2       copy of registered req_size
//  mem_rdata        in   32      memory read data, valid when mem_ready=1
//  mem_ready        in   1       memory completes the current access this cycle
// BEHAVIOUR
//  Reset (reset_n=0 at edge): state IDLE; every output 0 except req_ready=1. Reset mid-ACCESS
//   drops the strobes at that same edge; no rsp_valid is issued for the aborted access.
//  FSM: IDLE -> ACCESS -> RESP -> IDLE. Misaligned requests go IDLE -> RESP directly.
//  IDLE: req_ready=1. On req_valid=1, register we/size/unsigned/addr/wdata.
//   Misaligned means any of: size=11; size=01 with addr[0]=1; size=10 with addr[1:0]!=0.
//   Misaligned -> RESP with err=1; mem_* stays 0 (no memory cycle).
//  ACCESS: req_ready=0. Drive mem_rd_en=~we and mem_wr_en=we, with address/wdata/byte_en/length
//   held stable for the whole state.
//   mem_ready=0: remain in ACCESS (any number of wait states).
//   mem_ready=1: capture data, go to RESP; strobes drop on the next cycle.
//  Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
//  Write data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
//  Load extraction (little-endian):
//   byte lane = mem_rdata[8*addr[1:0]+:8]; half lane = mem_rdata[16*addr[1]+:16].
//   Extend to 32 bits by req_unsigned.
//  RESP: rsp_valid=1 for exactly one cycle, with rsp_rdata/rsp_err registered. Then IDLE.
//   req_ready=0 in RESP, so the minimum request-to-request spacing is 3 cycles.
//  Latency: request accepted at edge N; zero-wait memory gives rsp_valid in cycle N+2.
//  mem_ready is ignored outside ACCESS. req_valid is ignored outside IDLE.
// CONFIGURATION
//  LSU_TIMEOUT_EN defined: an 8-bit wait counter clears on entry to ACCESS and increments
//   each ACCESS cycle with mem_ready=0. After TIMEOUT_CYC such cycles, go to RESP with rsp_err=1,
//   rsp_rdata=0 and strobes dropped.
//  LSU_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely for mem_ready.
// TESTING
//  LW addr 0x100, mem_ready=1 at once, mem_rdata=0xDEADBEEF -> rsp_valid at N+2, rdata=0xDEADBEEF, err=0
//  LB addr 0x103, rdata=0x80FF_FFFF; unsigned=0 -> 0xFFFFFF80; unsigned=1 -> 0x00000080
//  SH addr 0x202, wdata=0x1234ABCD -> mem_wdata=0xABCDABCD, byte_en=1100, address=0x200, wr_en=1
//  LW addr 0x101 -> no mem strobe ever, rsp_valid at N+1 with err=1, rdata=0
//  LH addr 0x10, mem_ready low 5 cycles -> strobes held 6 cycles, rsp_valid 1 cycle after mem_ready
//  reset_n=0 during a waited ACCESS -> strobes 0 next edge, req_ready=1, no rsp_valid;
//   with LSU_TIMEOUT_EN and mem_ready stuck 0 -> err=1 after 16 wait cycles

Source files
------------

// File: rtl/rv32_lsu_ctrl.sv
// rv32_lsu_ctrl -- load/store access controller for a multicycle RV32I core.
//
// Sits between the core's control FSM and the data memory. The FSM makes a
// request with a valid/ready handshake. The controller then runs a single
// memory cycle and returns one response pulse. The controller handles:
//   - byte lane enables from size and address
//   - store data replicated across all lanes
//   - sign or zero extension of load data
//   - detection of misaligned and illegal sizes (no memory cycle is run)
//   - any number of memory wait states
//
// Optional feature: define LSU_TIMEOUT_EN to add a wait-state counter that
// aborts an access after TIMEOUT_CYC cycles with mem_ready low. The response
// for an aborted access has rsp_err=1.
//
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   req_valid / req_ready        request handshake (ready only in IDLE)
//   req_we, req_size,            store flag, size (00 B, 01 H, 10 W, 11 bad),
//   req_unsigned                 zero-extend flag for loads
//   req_addr, req_wdata          byte address, right-aligned store data
//   rsp_valid, rsp_rdata,        one-cycle completion pulse, extended load
//   rsp_err                      data, error flag
//   mem_rd_en, mem_wr_en         memory strobes (high for the whole ACCESS)
//   mem_address                  word-aligned address
//   mem_wdata, mem_byte_en       lane-replicated data, byte lane enables
//   mem_data_length              registered request size
//   mem_rdata, mem_ready         memory read data, access-complete flag
module rv32_lsu_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_byte_en,
    output logic [1:0]        mem_data_length,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

    state_t            state, state_next;
    logic              we_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              misaligned;
    logic              timeout_hit;
    logic [7:0]        byte_lane;
    logic [15:0]       half_lane;
    logic [31:0]       load_data;
    logic [3:0]        byte_en;
    logic [31:0]       wdata_rep;

    assign misaligned = (req_size == 2'b11) ||
                        (req_size == 2'b01 && req_addr[0]) ||
                        (req_size == 2'b10 && req_addr[1:0] != 2'b00);

`ifdef LSU_TIMEOUT_EN
    logic [7:0] wait_cnt;
    // The counter holds the number of wait cycles seen so far. Abort on the
    // cycle that would be wait number TIMEOUT_CYC.
    assign timeout_hit = !mem_ready && (wait_cnt == 8'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        case (addr_q[1:0])
            2'd0:    byte_lane = mem_rdata[7:0];
            2'd1:    byte_lane = mem_rdata[15:8];
            2'd2:    byte_lane = mem_rdata[23:16];
            default: byte_lane = mem_rdata[31:24];
        endcase
        half_lane = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   load_data = uns_q ? {24'd0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
            2'b01:   load_data = uns_q ? {16'd0, half_lane} : {{16{half_lane[15]}}, half_lane};
            default: load_data = mem_rdata;
        endcase
        // A store completes with zero read data.
        if (we_q) load_data = 32'd0;

        case (size_q)
            2'b00:   begin byte_en = 4'b0001 << addr_q[1:0]; wdata_rep = {4{wdata_q[7:0]}};  end
            2'b01:   begin byte_en = 4'b0011 << addr_q[1:0]; wdata_rep = {2{wdata_q[15:0]}}; end
            default: begin byte_en = 4'b1111;                wdata_rep = wdata_q;            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                rdata_q <= 32'd0;
                err_q   <= misaligned;
            end
            if (state == ACCESS && mem_ready) begin
                rdata_q <= load_data;
                err_q   <= 1'b0;
            end else if (state == ACCESS && timeout_hit) begin
                rdata_q <= 32'd0;
                err_q   <= 1'b1;
            end
        end
    end

`ifdef LSU_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset_n || state != ACCESS) wait_cnt <= 8'd0;
        else if (!mem_ready)             wait_cnt <= wait_cnt + 8'd1;
    end
`endif

    always_comb begin
        state_next      = state;
        req_ready       = 1'b0;
        rsp_valid       = 1'b0;
        rsp_rdata       = 32'd0;
        rsp_err         = 1'b0;
        mem_rd_en       = 1'b0;
        mem_wr_en       = 1'b0;
        mem_address     = '0;
        mem_wdata       = 32'd0;
        mem_byte_en     = 4'b0000;
        mem_data_length = 2'b00;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = misaligned ? RESP : ACCESS;
            end
            ACCESS: begin
                mem_rd_en       = ~we_q;
                mem_wr_en       = we_q;
                mem_address     = {addr_q[ADDR_W-1:2], 2'b00};
                mem_wdata       = wdata_rep;
                mem_byte_en     = byte_en;
                mem_data_length = size_q;
                if (mem_ready || timeout_hit) state_next = RESP;
            end
            RESP: begin
                rsp_valid  = 1'b1;
                rsp_rdata  = rdata_q;
                rsp_err    = err_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_rv32_lsu_ctrl.sv
module tb_rv32_lsu_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_rd_en, mem_wr_en;
    logic [31:0] mem_address, mem_wdata, mem_rdata;
    logic [3:0]  mem_byte_en;
    logic [1:0]  mem_data_length;
    logic        mem_ready;

    int total = 0;
    int bad   = 0;
    logic [32:0] exp_q[$];   // {err, rdata}

    always #5 clk = ~clk;

    rv32_lsu_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en),
        .mem_data_length(mem_data_length), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    // Response scoreboard: every rsp_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && rsp_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected: got err=%0b rdata=%h, none expected", rsp_err, rsp_rdata);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                if ({rsp_err, rsp_rdata} !== e) begin
                    bad++;
                    $display("FAIL rsp_data: got err=%0b rdata=%h, want err=%0b rdata=%h",
                             rsp_err, rsp_rdata, e[32], e[31:0]);
                end
            end
        end
    end

    task automatic test_reset;
        reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        mem_rdata = 32'd0; mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({req_ready, rsp_valid, rsp_err, mem_rd_en, mem_wr_en} !== 5'b10000) begin
            bad++;
            $display("FAIL reset_ctrl: got rdy/vld/err/rd/wr=%b, want 10000",
                     {req_ready, rsp_valid, rsp_err, mem_rd_en, mem_wr_en});
        end
        total++;
        if ({rsp_rdata, mem_address, mem_wdata, mem_byte_en, mem_data_length} !== 102'd0) begin
            bad++;
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h be=%b len=%b, want all 0",
                     rsp_rdata, mem_address, mem_wdata, mem_byte_en, mem_data_length);
        end
        @(posedge clk); #1 reset_n = 1'b1;
    endtask

    // One request. Aligned requests get `waits` wait cycles, then mem_ready.
    // The timing checks encode the latency: ACCESS runs in the cycles after
    // the accept edge, and rsp_valid is high in the cycle after mem_ready.
    task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input int waits,
                           input logic [31:0] exp_rd, input logic exp_err,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd);
        exp_q.push_back({exp_err, exp_rd});
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;
        if (!exp_err) begin
            for (int i = 0; i <= waits; i++) begin
                mem_ready = (i == waits);
                mem_rdata = (i == waits) ? rd : $urandom;
                @(negedge clk);
                total++;
                if ({mem_rd_en, mem_wr_en, req_ready, rsp_valid} !== {~we, we, 2'b00} ||
                    mem_address !== {addr[31:2], 2'b00} || mem_byte_en !== exp_be ||
                    mem_data_length !== sz || (we && mem_wdata !== exp_wd)) begin
                    bad++;
                    $display("FAIL access_%h_c%0d: rd=%b wr=%b rdy=%b vld=%b addr=%h be=%b len=%b wdata=%h, want rd=%b wr=%b addr=%h be=%b len=%b wdata=%h",
                             addr, i, mem_rd_en, mem_wr_en, req_ready, rsp_valid, mem_address,
                             mem_byte_en, mem_data_length, mem_wdata, ~we, we,
                             {addr[31:2], 2'b00}, exp_be, sz, exp_wd);
                end
                @(posedge clk); #1;
            end
            mem_ready = 1'b0;
        end
        @(negedge clk);
        total++;
        if ({rsp_valid, mem_rd_en, mem_wr_en, req_ready} !== 4'b1000) begin
            bad++;
            $display("FAIL resp_cycle_%h: vld/rd/wr/rdy=%b, want 1000", addr,
                     {rsp_valid, mem_rd_en, mem_wr_en, req_ready});
        end
        @(posedge clk); #1;
        total++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            bad++;
            $display("FAIL back_idle_%h: vld/rdy=%b, want 01", addr, {rsp_valid, req_ready});
        end
    endtask

    task automatic test_loads;
        run_req(0, 2'b10, 0, 32'h100, 0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 4'b1111, 0);
        run_req(0, 2'b00, 0, 32'h103, 0, 32'h80FFFFFF, 0, 32'hFFFFFF80, 0, 4'b1000, 0);
        run_req(0, 2'b00, 1, 32'h103, 0, 32'h80FFFFFF, 0, 32'h00000080, 0, 4'b1000, 0);
        run_req(0, 2'b00, 0, 32'h101, 0, 32'h00007F00, 0, 32'h0000007F, 0, 4'b0010, 0);
        run_req(0, 2'b01, 1, 32'h12,  0, 32'h80010000, 0, 32'h00008001, 0, 4'b1100, 0);
    endtask

    task automatic test_stores;
        run_req(1, 2'b01, 0, 32'h202, 32'h1234ABCD, 32'h55555555, 0, 0, 0, 4'b1100, 32'hABCDABCD);
        run_req(1, 2'b00, 0, 32'h001, 32'h000000A5, 32'h55555555, 0, 0, 0, 4'b0010, 32'hA5A5A5A5);
        run_req(1, 2'b10, 0, 32'h004, 32'hCAFEF00D, 32'h55555555, 0, 0, 0, 4'b1111, 32'hCAFEF00D);
    endtask

    task automatic test_misaligned;
        run_req(0, 2'b10, 0, 32'h101, 0, 0, 0, 0, 1, 0, 0);
        run_req(0, 2'b11, 0, 32'h000, 0, 0, 0, 0, 1, 0, 0);
        run_req(1, 2'b01, 0, 32'h003, 32'hFFFF, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_wait_states;
        run_req(0, 2'b01, 0, 32'h10, 0, 32'h12348765, 5, 32'hFFFF8765, 0, 4'b0011, 0);
    endtask

    task automatic test_ignored_inputs;
        // mem_ready high while IDLE must not produce a response.
        mem_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total++;
            if ({rsp_valid, mem_rd_en, req_ready} !== 3'b001) begin
                bad++;
                $display("FAIL idle_mem_ready: vld/rd/rdy=%b, want 001", {rsp_valid, mem_rd_en, req_ready});
            end
        end
        @(posedge clk); #1 mem_ready = 1'b0;
    endtask

    task automatic test_long_wait;
        int seen;
        exp_q.push_back({1'b1, 32'd0});
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h40;
        @(posedge clk); #1 req_valid = 1'b0;
        seen = 0;
        for (int i = 0; i < 40 && seen == 0; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = i + 1;
        end
`ifdef LSU_TIMEOUT_EN
        total++;
        if (seen != 17) begin
            bad++;
            $display("FAIL timeout_cycle: rsp at cycle %0d, want 17", seen);
        end
`else
        void'(exp_q.pop_back());
        total++;
        if (seen != 0 || mem_rd_en !== 1'b1) begin
            bad++;
            $display("FAIL long_wait: rsp at cycle %0d rd_en=%b, want none and 1", seen, mem_rd_en);
        end
        exp_q.push_back({1'b0, 32'h01020304});
        @(posedge clk); #1 mem_ready = 1'b1; mem_rdata = 32'h01020304;
        @(posedge clk); #1 mem_ready = 1'b0;
`endif
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid_access;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h80; req_wdata = 32'h11;
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({mem_rd_en, mem_wr_en, req_ready, rsp_valid} !== 4'b0010) begin
            bad++;
            $display("FAIL reset_mid_access: rd/wr/rdy/vld=%b, want 0010",
                     {mem_rd_en, mem_wr_en, req_ready, rsp_valid});
        end
        reset_n = 1'b1;
        mem_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 mem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_misaligned();
        test_wait_states();
        test_ignored_inputs();
        test_long_wait();
        test_reset_mid_access();
        repeat (2) @(posedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_rsp: %0d responses outstanding, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
